// File: rtl/clock_time_if.sv
// Bundle between the tick/button front end (master) and the time-keeping controller (slave).
// Inputs are plain one-cycle-sampled levels; all outputs are registered and held until the next change.
`timescale 1ns/1ps
interface clock_time_if;
  logic        sec_tick;
  logic        btn_mode;
  logic        btn_inc;
  logic [10:0] bin_time;
  logic [1:0]  set_mode;
  logic [5:0]  sec_count;

  modport master (
    output sec_tick, btn_mode, btn_inc,
    input  bin_time, set_mode, sec_count
  );

  modport slave (
    input  sec_tick, btn_mode, btn_inc,
    output bin_time, set_mode, sec_count
  );
endinterface

// File: rtl/clock_time_controller.sv
// 12-hour AM/PM clock with seconds prescale and a RUN / SET_HR / SET_MIN adjust FSM.
// set_mode doubles as the exposed FSM state.
`timescale 1ns/1ps
module clock_time_controller #(
  parameter int SEC_PER_MIN = 60
) (
  input  logic         clk,
  input  logic         reset,
  clock_time_if.slave  bus
);
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  localparam logic [5:0] SEC_LAST = 6'(SEC_PER_MIN - 1);

  mode_e       state, state_nx;
  logic        am, am_nx;
  logic [3:0]  hour, hour_nx;
  logic [5:0]  minute, minute_nx;
  logic [5:0]  sec, sec_nx;

  logic        mode_q, mode_d, mode_arm;
  logic        inc_q, inc_d, inc_arm;
  logic        mode_press, inc_press;
  logic [3:0]  hour_inc;
  logic        am_inc;
  logic [5:0]  minute_inc;
  logic        min_wrap;

  // The arm flags stay low while a button is held through reset, so the
  // cleared edge registers cannot fake a rising edge on release of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= 1'b0;
      mode_d   <= 1'b0;
      inc_q    <= 1'b0;
      inc_d    <= 1'b0;
      mode_arm <= ~bus.btn_mode;
      inc_arm  <= ~bus.btn_inc;
    end else begin
      mode_q   <= bus.btn_mode;
      mode_d   <= mode_q;
      inc_q    <= bus.btn_inc;
      inc_d    <= inc_q;
      mode_arm <= mode_arm | ~bus.btn_mode;
      inc_arm  <= inc_arm | ~bus.btn_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      am     <= 1'b1;
      hour   <= 4'd12;
      minute <= 6'd0;
      sec    <= 6'd0;
    end else begin
      state  <= state_nx;
      am     <= am_nx;
      hour   <= hour_nx;
      minute <= minute_nx;
      sec    <= sec_nx;
    end
  end

  always_comb begin
    mode_press = mode_q & ~mode_d & mode_arm;
    inc_press  = inc_q & ~inc_d & inc_arm & ~mode_press;
    hour_inc   = (hour == 4'd12) ? 4'd1 : hour + 4'd1;
    am_inc     = (hour == 4'd11) ? ~am : am;
    min_wrap   = (minute == 6'd59);
    minute_inc = min_wrap ? 6'd0 : minute + 6'd1;

    state_nx  = state;
    am_nx     = am;
    hour_nx   = hour;
    minute_nx = minute;
    sec_nx    = sec;

    unique case (state)
      RUN: begin
        if (mode_press) state_nx = SET_HR;
        if (bus.sec_tick) begin
          if (sec == SEC_LAST) begin
            sec_nx    = 6'd0;
            minute_nx = minute_inc;
            if (min_wrap) begin
              hour_nx = hour_inc;
              am_nx   = am_inc;
            end
          end else begin
            sec_nx = sec + 6'd1;
          end
        end
      end
      SET_HR: begin
        if (mode_press) begin
          state_nx = SET_MIN;
        end else if (inc_press) begin
          hour_nx = hour_inc;
          am_nx   = am_inc;
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_nx = RUN;
          sec_nx   = 6'd0;
        end else if (inc_press) begin
          minute_nx = minute_inc;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign bus.bin_time  = {am, hour, minute};
  assign bus.set_mode  = state;
  assign bus.sec_count = sec;
endmodule

// File: tb/tb_clock_time_controller.sv
// Bench for clock_time_controller: directed spec scenarios plus random traffic,
// scored every cycle against a minutes-of-day reference model.
`timescale 1ns/1ps
module tb_clock_time_controller;
  localparam int N = 4;
  localparam int W = 19;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clock_time_if bus();

  clock_time_controller #(.SEC_PER_MIN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // reference model: time as minutes since midnight (0..1439)
  function automatic logic [W-1:0] pack_exp(int mins, int mode, int sec);
    int   h24, h12;
    logic is_am;
    h24   = mins / 60;
    h12   = (h24 % 12 == 0) ? 12 : h24 % 12;
    is_am = (h24 < 12);
    return {is_am, 4'(h12), 6'(mins % 60), 2'(mode), 6'(sec)};
  endfunction

  int m_min, m_sec, m_mode;
  bit m_valid = 1'b0;
  bit pend_mode, pend_inc, prev_mode = 1'b1, prev_inc = 1'b1;
  bit mp, ip;

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_min = 0; m_sec = 0; m_mode = 0;
      m_valid = 1'b1;
    end else begin
      mp = pend_mode;
      ip = pend_inc && !pend_mode;
      case (m_mode)
        0: begin
          if (bus.sec_tick) begin
            m_sec = m_sec + 1;
            if (m_sec == N) begin
              m_sec = 0;
              m_min = (m_min + 1) % 1440;
            end
          end
          if (mp) m_mode = 1;
        end
        1: begin
          if (mp) m_mode = 2;
          else if (ip) m_min = (((m_min / 60) + 1) % 24) * 60 + m_min % 60;
        end
        default: begin
          if (mp) begin
            m_mode = 0;
            m_sec  = 0;
          end else if (ip) begin
            m_min = (m_min / 60) * 60 + (m_min % 60 + 1) % 60;
          end
        end
      endcase
    end
    // a press is a rising edge of the sampled level; it acts one clock later
    pend_mode = !reset && bus.btn_mode && !prev_mode;
    pend_inc  = !reset && bus.btn_inc && !prev_inc;
    prev_mode = bus.btn_mode;
    prev_inc  = bus.btn_inc;
    if (m_valid) exp_q.push_back(pack_exp(m_min, m_mode, m_sec));
  end

  // monitor
  logic [W-1:0] mon_e;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("cycle", {13'd0, bus.bin_time, bus.set_mode, bus.sec_count}, {13'd0, mon_e});
      check("range", {31'd0, (bus.bin_time[9:6] >= 4'd1 && bus.bin_time[9:6] <= 4'd12
                              && bus.bin_time[5:0] <= 6'd59)}, 32'd1);
    end
  end

  // driver tasks
  task automatic step_r(bit r, bit t, bit m, bit i);
    @(negedge clk);
    reset = r; bus.sec_tick = t; bus.btn_mode = m; bus.btn_inc = i;
  endtask

  task automatic step(bit t, bit m, bit i);
    step_r(1'b0, t, m, i);
  endtask

  task automatic settle();
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  task automatic do_reset(bit hold_mode);
    step_r(1'b1, 0, hold_mode, 0);
    step_r(1'b1, 0, hold_mode, 0);
    step_r(1'b0, 0, hold_mode, 0);
  endtask

  task automatic press_mode();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic press_inc();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic ticks(int n);
    repeat (n) step(1, 0, 0);
    settle();
  endtask

  task automatic set_time(int hp, int mpr);
    press_mode();
    repeat (hp) press_inc();
    press_mode();
    repeat (mpr) press_inc();
    press_mode();
    settle();
  endtask

  task automatic check_time(string name, bit am, int hr, int mn, int sc);
    check({name, "_time"}, {21'd0, bus.bin_time}, {21'd0, am, 4'(hr), 6'(mn)});
    check({name, "_sec"}, {26'd0, bus.sec_count}, 32'(sc));
  endtask

  initial begin
    reset = 1'b1;
    bus.sec_tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;

    do_reset(0);
    check_time("reset", 1, 12, 0, 0);
    check("reset_mode", {30'd0, bus.set_mode}, 32'd0);

    ticks(4);
    check_time("min_roll", 1, 12, 1, 0);

    do_reset(0);
    set_time(3, 61);
    check_time("set_seq", 1, 3, 1, 0);
    check("set_seq_mode", {30'd0, bus.set_mode}, 32'd0);

    do_reset(0);
    set_time(23, 59);
    ticks(3);
    check_time("preload", 0, 11, 59, 3);
    ticks(1);
    check_time("full_carry", 1, 12, 0, 0);

    do_reset(0);
    set_time(11, 59);
    ticks(4);
    check_time("am_to_pm", 0, 12, 0, 0);
    set_time(0, 59);
    ticks(4);
    check_time("pm_12_to_1", 0, 1, 0, 0);

    do_reset(0);
    press_mode();
    repeat (12) press_inc();
    settle();
    check_time("set_hr_ampm", 0, 12, 0, 0);
    check("set_hr_mode", {30'd0, bus.set_mode}, 32'd1);

    do_reset(0);
    ticks(1);
    step(0, 1, 1);
    step(0, 0, 0);
    settle();
    check("collide_mode", {30'd0, bus.set_mode}, 32'd1);
    check_time("collide_inc", 1, 12, 0, 1);
    press_mode();
    ticks(2);
    check("tick_set_min", {26'd0, bus.sec_count}, 32'd1);
    step(0, 1, 0);
    step(1, 0, 0);
    settle();
    check("exit_set_min_mode", {30'd0, bus.set_mode}, 32'd0);
    check("exit_set_min_sec", {26'd0, bus.sec_count}, 32'd0);

    do_reset(1);
    repeat (4) step(0, 1, 0);
    settle();
    check("held_reset", {30'd0, bus.set_mode}, 32'd0);
    press_mode();
    settle();
    check("after_release", {30'd0, bus.set_mode}, 32'd1);

    repeat (4000) begin
      step_r($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
    end
    settle();

    repeat (10) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
